// File: rtl/soc_pkg.sv
// Shared definitions for the memory-mapped peripherals: register offsets,
// STATUS bit positions and the UART transmitter state encoding.
package soc_pkg;

  localparam logic [1:0] REG_TXDATA = 2'd0;
  localparam logic [1:0] REG_STATUS = 2'd1;
  localparam logic [1:0] REG_DIV    = 2'd2;

  localparam int STAT_BUSY      = 0;
  localparam int STAT_FULL      = 1;
  localparam int STAT_EMPTY     = 2;
  localparam int STAT_COUNT_LSB = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO; dout always shows the head entry. Pushes while full and
// pops while empty are ignored. DEPTH must be a power of two.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         din,
  output logic [WIDTH-1:0]         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int CNT_W = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_mmio.sv
// Memory-mapped 8N1 UART transmitter: CPU stores fill a TX FIFO that a
// serial engine drains onto O_tx, with a programmable clocks-per-bit divider.
module uart_tx_mmio
  import soc_pkg::*;
#(
  parameter int CLK_DIV    = 417,
  parameter int FIFO_DEPTH = 16
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic        I_sel,
  input  logic [31:0] I_addr,
  input  logic [31:0] I_data,
  input  logic [3:0]  I_mask,
  input  logic        I_we,
  output logic [31:0] O_data,
  output logic        O_stall,
  output logic        O_tx
);

  localparam int          CW      = $clog2(FIFO_DEPTH) + 1;
  localparam logic [15:0] DIV_RST = 16'(CLK_DIV);

  logic [1:0]    reg_sel;
  logic          txdata_store;
  logic          push;
  logic          pop;
  logic [7:0]    fifo_head;
  logic          fifo_full;
  logic          fifo_empty;
  logic [CW-1:0] fifo_count;

  logic [15:0]   div_q;
  logic [15:0]   div_next;
  tx_state_e     state_q;
  tx_state_e     state_d;
  logic [15:0]   baud_q;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic          tx_q;
  logic          expire;
  logic          busy;
  logic [31:0]   status;
  logic          unused_bits;

  assign unused_bits = ^{I_addr[31:4], I_addr[1:0], I_data[31:16], I_mask[3:2]};

  // Handshake: a TXDATA store is accepted on the first edge where O_stall is
  // low; while the FIFO is full the CPU holds the bus and O_stall stays high.
  assign reg_sel      = I_addr[3:2];
  assign txdata_store = I_sel & I_we & (reg_sel == REG_TXDATA) & I_mask[0];
  assign push         = txdata_store & ~fifo_full;
  assign O_stall      = txdata_store & fifo_full;
  assign O_tx         = tx_q;
  assign expire       = (baud_q == 16'd0);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (I_clk),
    .rst   (I_rst),
    .push  (push),
    .pop   (pop),
    .din   (I_data[7:0]),
    .dout  (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // A divider of zero would stall the bit timer, so it is promoted to one.
  always_comb begin
    div_next = div_q;
    if (I_mask[0]) div_next[7:0]  = I_data[7:0];
    if (I_mask[1]) div_next[15:8] = I_data[15:8];
    if (div_next == 16'd0) div_next = 16'd1;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      div_q <= DIV_RST;
    end else if (I_sel && I_we && (reg_sel == REG_DIV)) begin
      div_q <= div_next;
    end
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) state_q <= TX_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    pop     = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          state_d = TX_START;
        end
      end
      TX_START: if (expire) state_d = TX_DATA;
      TX_DATA:  if (expire && (bitcnt_q == 3'd7)) state_d = TX_STOP;
      TX_STOP:  if (expire) state_d = TX_IDLE;
      default:  state_d = TX_IDLE;
    endcase
  end

  // The divider is sampled only on reload, so a DIV write never alters a bit
  // already in flight.
  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      tx_q     <= 1'b1;
      baud_q   <= '0;
      bitcnt_q <= '0;
      shift_q  <= '0;
    end else begin
      case (state_q)
        TX_IDLE: begin
          if (pop) begin
            shift_q <= fifo_head;
            tx_q    <= 1'b0;
            baud_q  <= div_q - 16'd1;
          end
        end
        TX_START: begin
          if (expire) begin
            tx_q     <= shift_q[0];
            baud_q   <= div_q - 16'd1;
            bitcnt_q <= '0;
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        TX_DATA: begin
          if (expire) begin
            baud_q <= div_q - 16'd1;
            if (bitcnt_q == 3'd7) begin
              tx_q <= 1'b1;
            end else begin
              shift_q  <= shift_q >> 1;
              tx_q     <= shift_q[1];
              bitcnt_q <= bitcnt_q + 3'd1;
            end
          end else begin
            baud_q <= baud_q - 16'd1;
          end
        end
        TX_STOP: begin
          if (!expire) baud_q <= baud_q - 16'd1;
        end
        default: tx_q <= 1'b1;
      endcase
    end
  end

  always_comb begin
    busy   = (state_q != TX_IDLE);
    status = '0;
    status[STAT_BUSY]             = busy;
    status[STAT_FULL]             = fifo_full;
    status[STAT_EMPTY]            = fifo_empty;
    status[STAT_COUNT_LSB +: 8]   = 8'(fifo_count);
    O_data = '0;
    if (I_sel) begin
      case (reg_sel)
        REG_STATUS: O_data = status;
        REG_DIV:    O_data = {16'd0, div_q};
        default:    O_data = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_mmio.sv
// Bench for uart_tx_mmio: a queue-and-bit-index model of the line, checked
// every cycle, plus literal waveform/register expectations.
module tb_uart_tx_mmio;

  localparam int DEPTH   = 16;
  localparam int RST_DIV = 417;
  localparam int LOG_N   = 65536;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic        I_sel = 1'b0;
  logic        I_we  = 1'b0;
  logic [31:0] I_addr = '0;
  logic [31:0] I_data = '0;
  logic [3:0]  I_mask = '0;
  logic [31:0] O_data;
  logic        O_stall;
  logic        O_tx;

  always #5 I_clk = ~I_clk;

  uart_tx_mmio #(.CLK_DIV(RST_DIV), .FIFO_DEPTH(DEPTH)) dut (
    .I_clk   (I_clk),
    .I_rst   (I_rst),
    .I_sel   (I_sel),
    .I_addr  (I_addr),
    .I_data  (I_data),
    .I_mask  (I_mask),
    .I_we    (I_we),
    .O_data  (O_data),
    .O_stall (O_stall),
    .O_tx    (O_tx)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  logic tx_log [LOG_N];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      if (n_fail <= 40)
        $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic bound_expired(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: wait bound expired (cycle %0d)", name, cyc);
  endtask

  // ---------------- behavioural model ----------------
  logic [7:0] m_q[$];
  int         m_div;
  bit         m_busy;
  int         m_bit;
  int         m_rem;
  logic [7:0] m_byte;
  logic       m_tx;
  bit         m_valid = 0;

  function automatic logic line_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    s = '0;
    s[0]    = m_busy;
    s[1]    = (m_q.size() == DEPTH);
    s[2]    = (m_q.size() == 0);
    s[15:8] = 8'(m_q.size());
    return s;
  endfunction

  function automatic logic [31:0] model_rdata();
    if (!I_sel) return '0;
    case (I_addr[3:2])
      2'd1:    return model_status();
      2'd2:    return {16'd0, 16'(m_div)};
      default: return '0;
    endcase
  endfunction

  function automatic logic model_stall();
    return I_sel && I_we && (I_addr[3:2] == 2'd0) && I_mask[0] && (m_q.size() == DEPTH);
  endfunction

  always @(posedge I_clk) begin
    int          sz;
    int          old_div;
    logic [15:0] nd;
    cyc++;
    if (I_rst) begin
      m_q.delete();
      m_div   = RST_DIV;
      m_busy  = 0;
      m_tx    = 1'b1;
      m_valid = 1;
    end else if (m_valid) begin
      sz      = m_q.size();
      old_div = m_div;
      if (m_busy) begin
        m_rem--;
        if (m_rem == 0) begin
          m_bit++;
          if (m_bit == 10) m_busy = 0;
          else begin
            m_rem = old_div;
            m_tx  = line_bit(m_byte, m_bit);
          end
        end
      end else if (sz > 0) begin
        m_byte = m_q.pop_front();
        m_busy = 1;
        m_bit  = 0;
        m_rem  = old_div;
        m_tx   = 1'b0;
      end
      if (I_sel && I_we && I_addr[3:2] == 2'd0 && I_mask[0] && sz < DEPTH)
        m_q.push_back(I_data[7:0]);
      if (I_sel && I_we && I_addr[3:2] == 2'd2) begin
        nd = 16'(m_div);
        if (I_mask[0]) nd[7:0]  = I_data[7:0];
        if (I_mask[1]) nd[15:8] = I_data[15:8];
        if (nd == 16'd0) nd = 16'd1;
        m_div = int'(nd);
      end
    end
  end

  always @(negedge I_clk) begin
    if (m_valid) begin
      check("tx_line", O_tx, m_tx);
      check("stall", O_stall, model_stall());
      check("rdata", O_data, model_rdata());
      if (cyc < LOG_N) tx_log[cyc] = O_tx;
    end
  end

  // ---------------- drivers (start and end at posedge + 1) ----------------
  task automatic bus_idle_inputs();
    I_sel = 0; I_we = 0; I_addr = '0; I_data = '0; I_mask = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge I_clk); #1; end
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m,
                           input bit sel, output int stalls, output int acc_cyc);
    I_sel = sel; I_we = 1; I_addr = {28'd0, a, 2'b00}; I_data = d; I_mask = m;
    stalls = 0;
    @(negedge I_clk);
    while (O_stall && stalls < 5000) begin
      stalls++;
      @(negedge I_clk);
    end
    if (stalls >= 5000) bound_expired("write_stall");
    @(posedge I_clk); #1;
    acc_cyc = cyc;
    bus_idle_inputs();
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] m);
    int s, c;
    bus_write(a, d, m, 1'b1, s, c);
  endtask

  task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
    I_sel = 1; I_we = 0; I_addr = {28'd0, a, 2'b00}; I_mask = '0;
    @(negedge I_clk);
    d = O_data;
    @(posedge I_clk); #1;
    bus_idle_inputs();
  endtask

  task automatic pulse_reset();
    I_rst = 1;
    @(posedge I_clk); #1;
    I_rst = 0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((m_q.size() > 0 || m_busy) && n < 20000) begin
      @(posedge I_clk); #1;
      n++;
    end
    if (n >= 20000) bound_expired("drain");
    idle(2);
  endtask

  // ---------------- directed + random sequence ----------------
  logic [31:0] rd;
  int          w;
  int          st;
  int          c0;
  int          stalls [18];
  logic [7:0]  bytes18 [18];
  string       pat;
  int          pos;
  int          nf;
  logic [7:0]  dec;
  int          r;

  initial begin
    bus_idle_inputs();
    I_rst = 1;
    idle(3);
    I_rst = 0;

    // Reset state
    check("reset_tx", O_tx, 1'b1);
    bus_read(2'd1, rd); check("reset_status", rd, 32'h0000_0004);
    bus_read(2'd2, rd); check("reset_div", rd, 32'd417);

    // DIV=4, single 0x55 frame with literal waveform
    wr(2'd2, 32'h0000_0004, 4'b0011);
    bus_write(2'd0, 32'h0000_0055, 4'b0001, 1'b1, st, w);
    idle(2);
    bus_read(2'd1, rd); check("busy_in_frame", rd, 32'h0000_0005);
    idle(50);
    bus_read(2'd1, rd); check("idle_after_frame", rd, 32'h0000_0004);
    pat = {"1", "0000", "11110000111100001111000011110000", "11111111"};
    for (int i = 0; i < 45; i++)
      check($sformatf("frame55_%0d", i), tx_log[w+i], (pat[i] == "1") ? 1'b1 : 1'b0);

    // DIV=2, 18 back-to-back stores
    c0 = cyc;
    wr(2'd2, 32'h0000_0002, 4'b0011);
    for (int i = 0; i < 18; i++) bytes18[i] = 8'($urandom_range(0, 255));
    for (int i = 0; i < 18; i++) bus_write(2'd0, {24'd0, bytes18[i]}, 4'b0001, 1'b1, stalls[i], w);
    for (int i = 0; i < 17; i++) check($sformatf("no_stall_%0d", i), stalls[i], 0);
    check("stall18_cycles", stalls[17], 6);
    drain();
    pos = c0 + 1;
    nf  = 0;
    while (nf < 18 && pos < cyc - 20) begin
      if (tx_log[pos] == 1'b0 && tx_log[pos-1] == 1'b1) begin
        for (int j = 0; j < 8; j++) dec[j] = tx_log[pos + 2*(j+1)];
        check($sformatf("order_%0d", nf), dec, bytes18[nf]);
        nf++;
        pos = pos + 20;
      end else begin
        pos++;
      end
    end
    check("frames_seen", nf, 18);

    // STATUS mid-frame with DIV=100
    wr(2'd2, 32'h0000_0064, 4'b0011);
    wr(2'd0, 32'h0000_00A1, 4'b0001);
    wr(2'd0, 32'h0000_00B2, 4'b0001);
    wr(2'd0, 32'h0000_00C3, 4'b0001);
    bus_read(2'd1, rd); check("status_mid", rd, 32'h0000_0201);
    bus_read(2'd3, rd); check("offset3_read", rd, 32'h0);
    bus_read(2'd0, rd); check("txdata_read", rd, 32'h0);

    // DIV write masking and zero promotion
    wr(2'd2, 32'h0000_0000, 4'b0001);
    bus_read(2'd2, rd); check("div_zero_to_one", rd, 32'h0000_0001);
    wr(2'd2, 32'hFFFF_1234, 4'b0011);
    bus_read(2'd2, rd); check("div_1234", rd, 32'h0000_1234);
    bus_write(2'd2, 32'h0000_0777, 4'b0011, 1'b0, st, w);
    bus_read(2'd2, rd); check("div_unselected", rd, 32'h0000_1234);
    wr(2'd2, 32'h0000_5600, 4'b0010);
    bus_read(2'd2, rd); check("div_hi_byte", rd, 32'h0000_5634);
    pulse_reset();

    // TXDATA store without byte 0 enable
    wr(2'd0, 32'h0000_0077, 4'b0010);
    bus_read(2'd1, rd); check("nomask_status", rd, 32'h0000_0004);
    idle(5);
    check("nomask_tx", O_tx, 1'b1);

    // Reset in the middle of a data bit with bytes queued
    wr(2'd2, 32'h0000_0008, 4'b0011);
    for (int i = 0; i < 5; i++) wr(2'd0, 32'h0000_0000 | (8'h30 + i), 4'b0001);
    idle(20);
    pulse_reset();
    @(negedge I_clk);
    check("rst_mid_tx", O_tx, 1'b1);
    @(posedge I_clk); #1;
    bus_read(2'd1, rd); check("rst_mid_status", rd, 32'h0000_0004);
    bus_read(2'd2, rd); check("rst_mid_div", rd, 32'd417);

    // Random traffic with small dividers
    wr(2'd2, 32'($urandom_range(1, 4)), 4'b0011);
    for (int k = 0; k < 400; k++) begin
      r = $urandom_range(0, 99);
      if (r < 45) begin
        bus_write(2'd0, $urandom(),
                  ($urandom_range(0, 9) == 0) ? 4'b1110 : (4'($urandom_range(0, 15)) | 4'b0001),
                  1'b1, st, w);
      end else if (r < 55) begin
        bus_read(2'($urandom_range(0, 3)), rd);
      end else if (r < 62) begin
        wr(2'd2, {16'($urandom()), 8'd0, 8'($urandom_range(0, 5))}, 4'($urandom_range(1, 3)));
      end else if (r < 66) begin
        bus_write(2'($urandom_range(0, 3)), $urandom(), 4'($urandom_range(0, 15)), 1'b0, st, w);
      end else if (r < 70) begin
        bus_write(($urandom_range(0, 1) == 0) ? 2'd1 : 2'd3, $urandom(), 4'hF, 1'b1, st, w);
      end else if (r < 72) begin
        pulse_reset();
        wr(2'd2, 32'($urandom_range(1, 5)), 4'b0011);
      end else begin
        idle($urandom_range(1, 5));
      end
    end
    drain();
    bus_read(2'd1, rd); check("final_status", rd, 32'h0000_0004);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
